// File: rtl/button_reader.sv
// button_reader: synchronises, debounces and classifies a raw push-button pin into
// level, press/release/long-press pulses and a wrapping press counter.
module button_reader #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int LONG_CYCLES = 16,
  parameter int COUNT_WIDTH = 8,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_button,
  input  logic                   i_clear_count,
  output logic                   o_level,
  output logic                   o_press,
  output logic                   o_release,
  output logic                   o_long,
  output logic [COUNT_WIDTH-1:0] o_count
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] H_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] H_MAX = HW'(LONG_CYCLES);
  typedef enum logic [1:0] {UP, PRESS_CHK, DOWN, RELEASE_CHK} state_t;
  state_t state;
  logic sync1, sync2, s;
  logic [DW-1:0] dcnt;
  logic [HW-1:0] hold;
  assign s = sync2 ^ ACTIVE_LOW;
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      sync1 <= ACTIVE_LOW;
      sync2 <= ACTIVE_LOW;
      state <= UP;
      dcnt <= '0;
      hold <= '0;
      o_level <= 1'b0;
      o_press <= 1'b0;
      o_release <= 1'b0;
      o_long <= 1'b0;
      o_count <= '0;
    end else begin
      sync1 <= i_button;
      sync2 <= sync1;
      o_press <= 1'b0;
      o_release <= 1'b0;
      o_long <= 1'b0;
      case (state)
        UP: if (s) begin
          state <= PRESS_CHK;
          dcnt <= DW'(1);
        end
        PRESS_CHK: if (!s) begin
          state <= UP;
          dcnt <= '0;
        end else if (dcnt == D_LAST) begin
          state <= DOWN;
          o_level <= 1'b1;
          o_press <= 1'b1;
          o_count <= o_count + COUNT_WIDTH'(1);
          hold <= '0;
        end else dcnt <= dcnt + DW'(1);
        DOWN: begin
          // hold saturates so the long pulse can only fire once per press
          if (hold != H_MAX) hold <= hold + HW'(1);
          if (hold == H_LAST) o_long <= 1'b1;
          if (!s) begin
            state <= RELEASE_CHK;
            dcnt <= DW'(1);
          end
        end
        RELEASE_CHK: if (s) begin
          state <= DOWN;
          dcnt <= '0;
        end else if (dcnt == D_LAST) begin
          state <= UP;
          o_level <= 1'b0;
          o_release <= 1'b1;
        end else dcnt <= dcnt + DW'(1);
        default: state <= UP;
      endcase
      // placed after the FSM so a clear beats a same-edge increment
      if (i_clear_count) o_count <= '0;
    end
  end
endmodule

// File: tb/tb_button_reader.sv
// tb_button_reader: scoreboard bench for three button_reader configurations.
module tb_button_reader;
  typedef struct {int cyc; int kind; int cnt; int lvl;} ev_t;
  logic clk;
  logic [2:0] rst, btn, clr;
  logic [2:0] lvl, prs, rel, lng;
  logic [7:0] cnt_a;
  logic [3:0] cnt_b;
  logic [7:0] cnt_c;
  int cyc, checks, errors;
  ev_t q[3][$];

  button_reader u_a (.i_clock(clk), .i_reset(rst[0]), .i_button(btn[0]), .i_clear_count(clr[0]),
    .o_level(lvl[0]), .o_press(prs[0]), .o_release(rel[0]), .o_long(lng[0]), .o_count(cnt_a));
  button_reader #(.COUNT_WIDTH(4)) u_b (.i_clock(clk), .i_reset(rst[1]), .i_button(btn[1]),
    .i_clear_count(clr[1]), .o_level(lvl[1]), .o_press(prs[1]), .o_release(rel[1]), .o_long(lng[1]),
    .o_count(cnt_b));
  button_reader #(.ACTIVE_LOW(1'b1)) u_c (.i_clock(clk), .i_reset(rst[2]), .i_button(btn[2]),
    .i_clear_count(clr[2]), .o_level(lvl[2]), .o_press(prs[2]), .o_release(rel[2]), .o_long(lng[2]),
    .o_count(cnt_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(int id, int c, int kind, int n, int lv);
    ev_t e;
    e.cyc = c; e.kind = kind; e.cnt = n; e.lvl = lv;
    q[id].push_back(e);
  endtask

  task automatic mon(int id, logic p, logic r, logic l, logic lv, int c);
    int kind;
    ev_t e;
    kind = int'(p) | (int'(r) << 1) | (int'(l) << 2);
    if (q[id].size() != 0 && q[id][0].cyc < cyc) begin
      e = q[id].pop_front();
      checks++;
      errors++;
      $display("FAIL d%0d_missed kind %0d due cycle %0d, now %0d", id, e.kind, e.cyc, cyc);
    end
    if (kind != 0) begin
      if (q[id].size() == 0) begin
        checks++;
        errors++;
        $display("FAIL d%0d_unexpected kind %0d at cycle %0d", id, kind, cyc);
      end else begin
        e = q[id].pop_front();
        chk($sformatf("d%0d_cycle", id), cyc, e.cyc);
        chk($sformatf("d%0d_kind", id), kind, e.kind);
        chk($sformatf("d%0d_count", id), c, e.cnt);
        chk($sformatf("d%0d_level", id), int'(lv), e.lvl);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, prs[0], rel[0], lng[0], lvl[0], int'(cnt_a));
    mon(1, prs[1], rel[1], lng[1], lvl[1], int'(cnt_b));
    mon(2, prs[2], rel[2], lng[2], lvl[2], int'(cnt_c));
  end

  // press for 'hold' cycles then release; optional clear on the press edge
  task automatic press(int id, int hold, int n, bit clr_at_press);
    logic on;
    int k, m;
    on = (id == 2) ? 1'b0 : 1'b1;
    btn[id] = on;
    k = cyc + 1;
    push(id, k + 5, 1, n, 1);
    if (hold >= 20) push(id, k + 21, 4, n, 1);
    if (clr_at_press) begin
      tick(5);
      clr[id] = 1'b1;
      tick(1);
      clr[id] = 1'b0;
      tick(hold - 6);
    end else tick(hold);
    btn[id] = ~on;
    m = cyc + 1;
    push(id, m + 5, 2, n, 0);
    tick(10);
  endtask

  task automatic chk_idle(string nm, int id, int c);
    chk({nm, "_level"}, int'(lvl[id]), 0);
    chk({nm, "_pulses"}, int'(prs[id]) + int'(rel[id]) + int'(lng[id]), 0);
    chk({nm, "_count"}, c, 0);
  endtask

  initial begin
    int k;
    cyc = 0; checks = 0; errors = 0;
    rst = 3'b111; btn = 3'b100; clr = 3'b000;
    tick(3);
    chk_idle("rst_a", 0, int'(cnt_a));
    chk_idle("rst_b", 1, int'(cnt_b));
    chk_idle("rst_c", 2, int'(cnt_c));
    rst = 3'b000;
    tick(20);
    chk_idle("idle_a", 0, int'(cnt_a));
    chk_idle("idle_c", 2, int'(cnt_c));
    // long press with release
    press(0, 40, 1, 0);
    chk("long_count", int'(cnt_a), 1);
    // bounce after a fresh reset
    rst[0] = 1'b1; tick(1); rst[0] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      btn[0] = 1'b1; tick(3);
      btn[0] = 1'b0; tick(2);
    end
    press(0, 10, 1, 0);
    chk("bounce_count", int'(cnt_a), 1);
    press(0, 10, 2, 0);
    // reset while pressed, 8 cycles after the press pulse
    btn[0] = 1'b1;
    k = cyc + 1;
    push(0, k + 5, 1, 3, 1);
    tick(13);
    rst[0] = 1'b1; btn[0] = 1'b0;
    tick(1);
    chk_idle("midrst_a", 0, int'(cnt_a));
    rst[0] = 1'b0;
    tick(20);
    chk_idle("postrst_a", 0, int'(cnt_a));
    // 4-bit counter wrap and clear on the press edge
    for (int i = 1; i <= 16; i++) press(1, 8, i % 16, 0);
    chk("wrap_count", int'(cnt_b), 0);
    press(1, 8, 0, 1);
    chk("clear_count", int'(cnt_b), 0);
    // active-low pin
    press(2, 8, 1, 0);
    press(2, 24, 2, 0);
    tick(30);
    for (int i = 0; i < 3; i++) chk($sformatf("d%0d_drain", i), q[i].size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
